// File: rtl/l4_datapath.sv
// l4 multi-cycle processor datapath: pc, IL, 8-entry register file, A/G, adder/subtractor and display on one shared bus.
// Optional macro L4_BUS_CHECK_EN builds a sticky bus-contention flag; otherwise bus_err is tied low.
module l4_datapath #(
  parameter int DATA_W = 8,
  parameter int PC_W   = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              _Extern,
  input  logic              Gout,
  input  logic              Iout,
  input  logic              Ain,
  input  logic              Gin,
  input  logic              DPin,
  input  logic              RdX,
  input  logic              RdY,
  input  logic              WrX,
  input  logic              add_sub,
  input  logic              pc_en,
  input  logic              ILin,
  input  logic [8:0]        instr_in,
  input  logic [DATA_W-1:0] data_in,
  output logic [PC_W-1:0]   pc,
  output logic [2:0]        operation,
  output logic [DATA_W-1:0] disp,
  output logic [DATA_W-1:0] bus,
  output logic              bus_err
);

  logic [8:0]        il;
  logic [DATA_W-1:0] a, g, alu, imm;
  logic [DATA_W-1:0] rf [8];
  logic [2:0]        x_sel, y_sel;

  assign x_sel = il[5:3];
  assign y_sel = il[2:0];
  assign imm   = DATA_W'(il[2:0]);

  // State machine numbers its opcode port [0:2], so IL[8] lands on bit 0.
  assign operation = {il[6], il[7], il[8]};

  always_comb begin
    bus = '0;
    if (_Extern)   bus = data_in;
    else if (Gout) bus = g;
    else if (Iout) bus = imm;
    else if (RdX)  bus = rf[x_sel];
    else if (RdY)  bus = rf[y_sel];
  end

  assign alu = add_sub ? (a - bus) : (a + bus);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc   <= '0;
      il   <= '0;
      a    <= '0;
      g    <= '0;
      disp <= '0;
      for (int i = 0; i < 8; i++) rf[i] <= '0;
    end else begin
      if (pc_en) pc   <= pc + 1'b1;
      if (ILin)  il   <= instr_in;
      if (Ain)   a    <= bus;
      if (Gin)   g    <= alu;
      if (DPin)  disp <= bus;
      if (WrX)   rf[x_sel] <= bus;
    end
  end

`ifdef L4_BUS_CHECK_EN
  logic [2:0] src_cnt;
  assign src_cnt = 3'(_Extern) + 3'(Gout) + 3'(Iout) + 3'(RdX) + 3'(RdY);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)              bus_err <= 1'b0;
    else if (src_cnt >= 3'd2) bus_err <= 1'b1;
  end
`else
  assign bus_err = 1'b0;
`endif

endmodule

// File: tb/tb_l4_datapath.sv
// Directed test of l4_datapath: reset, fetch/wrap, load/display, ADD, SUBI and bus contention.
module tb_l4_datapath;
  localparam int DATA_W = 8;
  localparam int PC_W   = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic              ext, gout, iout, ain, gin, dpin, rdx, rdy, wrx, add_sub, pc_en, ilin;
  logic [8:0]        instr_in;
  logic [DATA_W-1:0] data_in;
  logic [PC_W-1:0]   pc;
  logic [2:0]        operation;
  logic [DATA_W-1:0] disp, bus;
  logic              bus_err;

  int checks = 0;
  int errors = 0;

`ifdef L4_BUS_CHECK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  l4_datapath #(.DATA_W(DATA_W), .PC_W(PC_W)) dut (
    .clk(clk), .reset(reset), ._Extern(ext), .Gout(gout), .Iout(iout), .Ain(ain),
    .Gin(gin), .DPin(dpin), .RdX(rdx), .RdY(rdy), .WrX(wrx), .add_sub(add_sub),
    .pc_en(pc_en), .ILin(ilin), .instr_in(instr_in), .data_in(data_in),
    .pc(pc), .operation(operation), .disp(disp), .bus(bus), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    {ext, gout, iout, ain, gin, dpin, rdx, rdy, wrx, add_sub, pc_en, ilin} = '0;
  endtask

  // Drive after the active edge, then advance one edge and settle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_il(input logic [8:0] w);
    clr(); instr_in = w; ilin = 1'b1; step(); clr();
  endtask

  task automatic load_reg(input logic [2:0] x, input logic [DATA_W-1:0] v);
    load_il({3'b000, x, 3'b000});
    ext = 1'b1; wrx = 1'b1; data_in = v; step(); clr();
  endtask

  initial begin
    clr();
    reset = 1'b1; instr_in = '0; data_in = '0;
    #12;
    chk("rst_pc", pc, 0);
    chk("rst_op", operation, 0);
    chk("rst_disp", disp, 0);
    chk("rst_bus", bus, 0);
    chk("rst_err", bus_err, 0);
    @(negedge clk); reset = 1'b0;
    #1; step();

    // Build some state: IL nonzero, pc=7, A=0x33, disp=0x33, G=0x33, R0=0x33
    instr_in = 9'b100_000_000; ilin = 1'b1; pc_en = 1'b1; step(); clr();
    chk("op_map", operation, 3'b001);
    chk("pc_1", pc, 1);
    pc_en = 1'b1; repeat (6) step(); clr();
    chk("pc_7", pc, 7);
    ext = 1'b1; data_in = 8'h33; ain = 1'b1; dpin = 1'b1; step(); clr();
    chk("disp_33", disp, 8'h33);
    gin = 1'b1; step(); clr();
    gout = 1'b1; wrx = 1'b1; #1;
    chk("g_33", bus, 8'h33);
    step(); clr();

    // Asynchronous reset in mid-cycle
    #2; reset = 1'b1; #1;
    chk("arst_pc", pc, 0);
    chk("arst_op", operation, 0);
    chk("arst_disp", disp, 0);
    chk("arst_bus", bus, 0);
    chk("arst_err", bus_err, 0);
    @(negedge clk); reset = 1'b0;
    #1; step();
    gout = 1'b1; #1; chk("arst_g", bus, 0); clr();
    rdx = 1'b1; #1; chk("arst_r0", bus, 0); clr();
    gin = 1'b1; step(); clr();
    gout = 1'b1; #1; chk("arst_a", bus, 0); clr();
    for (int i = 0; i < 8; i++) begin
      load_il({3'b000, 3'(i), 3'b000});
      rdx = 1'b1; #1; chk($sformatf("arst_r%0d", i), bus, 0); clr();
    end

    // Fetch and pc wrap
    chk("fetch_pc0", pc, 0);
    instr_in = 9'b000_011_000; ilin = 1'b1; pc_en = 1'b1; step();
    chk("fetch_op", operation, 0);
    chk("fetch_pc1", pc, 1);
    repeat (31) step(); clr();
    chk("pc_wrap", pc, 0);

    // Load and display via X=3
    ext = 1'b1; wrx = 1'b1; data_in = 8'h25; step(); clr();
    dpin = 1'b1; rdx = 1'b1; #1;
    chk("rdx_r3", bus, 8'h25);
    step(); clr();
    chk("disp_25", disp, 8'h25);

    // ADD with wrap
    load_reg(3'd1, 8'h10);
    load_reg(3'd2, 8'hF5);
    load_il(9'b011_001_010);
    chk("add_op", operation, 3'b110);
    ain = 1'b1; rdy = 1'b1; #1; chk("add_bus_y", bus, 8'hF5); step(); clr();
    gin = 1'b1; rdx = 1'b1; #1; chk("add_bus_x", bus, 8'h10); step(); clr();
    gout = 1'b1; wrx = 1'b1; #1; chk("add_g", bus, 8'h05); step(); clr();
    rdx = 1'b1; #1; chk("add_r1", bus, 8'h05); clr();
    rdy = 1'b1; #1; chk("add_r2", bus, 8'hF5); clr();

    // MV: G = A + 0 with no bus source
    gin = 1'b1; step(); clr();
    gout = 1'b1; #1; chk("mv_g", bus, 8'hF5); clr();

    // SUBI
    load_reg(3'd4, 8'h03);
    load_il(9'b110_100_101);
    chk("subi_op", operation, 3'b011);
    ain = 1'b1; rdx = 1'b1; step(); clr();
    gin = 1'b1; iout = 1'b1; add_sub = 1'b1; #1; chk("subi_imm", bus, 8'h05); step(); clr();
    gout = 1'b1; wrx = 1'b1; step(); clr();
    rdx = 1'b1; #1; chk("subi_r4", bus, 8'hFE); clr();

    // X == Y
    load_il(9'b000_100_100);
    rdy = 1'b1; #1; chk("xy_same", bus, 8'hFE); clr();
    chk("no_err_yet", bus_err, 0);

    // Contention: Iout beats RdX; flag is sticky until reset
    load_reg(3'd6, 8'h40);
    load_il(9'b000_110_101);
    rdx = 1'b1; #1; chk("cont_rdx", bus, 8'h40);
    iout = 1'b1; #1; chk("cont_bus", bus, 8'h05);
    chk("cont_pre", bus_err, 0);
    step(); clr();
    chk("cont_err", bus_err, ERR_EXP);
    ext = 1'b1; gout = 1'b1; data_in = 8'hA7; #1;
    chk("prio_ext", bus, 8'hA7); clr();
    repeat (3) step();
    chk("cont_sticky", bus_err, ERR_EXP);
    #2; reset = 1'b1; #1;
    chk("cont_rst", bus_err, 0);
    @(negedge clk); reset = 1'b0;
    step();
    chk("cont_after", bus_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: observed no finish expected finish by 50000");
    $fatal(1, "timeout");
  end
endmodule
